vmp_argmax_reader: RTL and testbench
====================================

// Module: vmp_argmax_reader
// PURPOSE
//  Consumer of the VectorMatrixProduct score bus: it reads the packed signed fixed-point class scores and classifies them.
//  Captures one score vector via valid/ready, scans the lanes serially (one per clock), and reports:
//    - arg-max class index, max score, margin (best minus runner-up).
//  Sits between the VMP and the system controller.
// PARAMETERS
//  NUM_CLASSES  10  number of score lanes (>=2)
//  SCORE_W      26  lane width, signed two's complement Q8.18
//  FRAC_W       18  fractional bits (documentation/bench only; no rescaling done)
//  IDX_W         4  width of class index, >= clog2(NUM_CLASSES)
// PORTS
//  clk          in   1                     rising-edge clock
//  GlobalReset  in   1                     asynchronous, active-low reset
//  in_valid     in   1                     score vector valid
//  in_ready     out  1                     block can accept a vector (high only in IDLE)
//  scores       in   NUM_CLASSES*SCORE_W   lane k = scores[k*SCORE_W +: SCORE_W]
//  out_valid    out  1                     result valid
//  out_ready    in   1                     downstream accepts result
//  digit        out  IDX_W                 arg-max lane index
//  max_score    out  SCORE_W               value of winning lane (signed)
//  margin       out  SCORE_W+1             unsigned best - second-best
// BEHAVIOUR
//  Reset (GlobalReset=0, async):
//    - state=IDLE; in_ready=1; out_valid=0; digit=0; max_score=0; margin=0.
//    - Internal buffer and counter are cleared.
//  FSM states: IDLE, SCAN, DONE.
//  IDLE:
//    - in_ready=1.
//    - On in_valid&in_ready: register all scores into buffer, cnt<=0, -> SCAN.
//  SCAN:
//    - in_ready=0. Each cycle, lane L = buffer lane cnt is compared; cnt increments.
//    - cnt==0: best<=L, second<=most-negative (1<<(SCORE_W-1)), idx<=0.
//    - L > best (signed): second<=best, best<=L, idx<=cnt.
//    - else if L > second: second<=L.
//    - Ties keep the lowest index; an equal value becomes second, giving margin 0.
//    - After lane NUM_CLASSES-1: -> DONE, out_valid<=1.
//      digit/max_score/margin are registered on the same edge.
//  Latency:
//    - out_valid rises exactly NUM_CLASSES clocks after the accepting edge (10 by default).
//    - Throughput: one vector per NUM_CLASSES+2 clocks minimum.
//  DONE:
//    - Outputs are held stable while out_valid&!out_ready; in_ready=0, so in_valid is ignored.
//    - On out_valid&out_ready: -> IDLE, out_valid<=0.
//    - digit/max_score/margin keep their last values.
//    - No accept in the same cycle as the release.
//  Arithmetic:
//    - Compares are signed, SCORE_W bits.
//    - margin = sign-extended best - sign-extended second, computed at SCORE_W+1 bits; never negative, no saturation needed.
//  Input stability:
//    - scores are sampled only on the accept edge.
//    - Changes to scores during SCAN/DONE have no effect.
//  Reset mid-SCAN/DONE: immediate return to reset values; the partial scan is discarded.
// STRUCTURE
//  Shared package vmp_pkg holds:
//    - NUM_CLASSES, SCORE_W, FRAC_W, IDX_W defaults.
//    - FSM state encoding constants.
//    - Lane-select function get_lane(vec,k).
//  Sub-module vmp_max2_update (combinational):
//    - Inputs (lane, best, second, idx, cnt, first).
//    - Outputs next (best, second, idx).
//  Top level holds the FSM, cnt, buffer and output registers.
// TESTING
//  1 Reset: GlobalReset=0 -> in_ready=1, out_valid=0, digit=0, max_score=0, margin=0.
//  2 All lanes 0x0C80000 (50.0) -> digit=0, max_score=0x0C80000, margin=0.
//  3 lane7=0x00E0000 (+3.5), others 0x3FC0000 (-1.0):
//    -> digit=7, max_score=0x00E0000, margin=0x0120000 (4.5).
//    -> out_valid exactly 10 clks after accept.
//  4 lane9=0x1FFFFFF, all others 0x2000000 -> digit=9, margin=0x3FFFFFF.
//  5 Backpressure: hold out_ready=0 for 20 clks with in_valid=1.
//    -> outputs stable, in_ready=0.
//    -> out_ready=1: IDLE next clk, in_ready=1.
//  6 GlobalReset pulsed low during SCAN at cnt=4:
//    -> outputs return to reset values asynchronously.
//    -> the next vector (case 3 data) yields digit=7.

Source files
------------

// File: rtl/vmp_argmax_reader_pkg.sv
// Shared sizing, FSM encoding and lane helpers for the VMP score-bus arg-max reader.
// Scores are signed Q8.18; no rescaling is ever applied, FRAC_W only documents the format.
package vmp_argmax_reader_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 26;
    localparam int FRAC_W      = 18;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic signed [SCORE_W-1:0]     score_t;
    typedef logic [NUM_CLASSES*SCORE_W-1:0] score_vec_t;
    typedef logic [IDX_W-1:0]               idx_t;
    typedef logic [SCORE_W:0]               margin_t;

    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    function automatic score_t get_lane(input score_vec_t vec, input int k);
        return score_t'(vec[k*SCORE_W +: SCORE_W]);
    endfunction

endpackage

// File: rtl/vmp_argmax_reader_if.sv
// Score-vector input handshake plus classification result handshake.
// slave = the reader, master = the side that supplies scores and accepts results.
interface vmp_argmax_reader_if;
    import vmp_argmax_reader_pkg::*;

    logic       in_valid;
    logic       in_ready;
    score_vec_t scores;
    logic       out_valid;
    logic       out_ready;
    idx_t       digit;
    score_t     max_score;
    margin_t    margin;

    modport slave (
        input  in_valid, scores, out_ready,
        output in_ready, out_valid, digit, max_score, margin
    );

    modport master (
        output in_valid, scores, out_ready,
        input  in_ready, out_valid, digit, max_score, margin
    );
endinterface

// File: rtl/vmp_argmax_reader_max2_update.sv
// Purpose: one step of a running best/second-best search over signed lanes.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the results.
module vmp_argmax_reader_max2_update
    import vmp_argmax_reader_pkg::*;
(
    input  score_t lane,
    input  score_t best,
    input  score_t second,
    input  idx_t   idx,
    input  idx_t   cnt,
    input  logic   first,
    output score_t nxt_best,
    output score_t nxt_second,
    output idx_t   nxt_idx
);

    always_comb begin
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = idx;
        if (first) begin
            nxt_best   = lane;
            nxt_second = SCORE_MIN;
            nxt_idx    = '0;
        end else if (lane > best) begin
            nxt_best   = lane;
            nxt_second = best;
            nxt_idx    = cnt;
        end else if (lane > second) begin
            // strict compare keeps the lowest index on ties; the tie lands in second
            nxt_second = lane;
        end
    end

endmodule

// File: rtl/vmp_argmax_reader.sv
// Purpose: capture one score vector, scan lanes serially, report arg-max, max score and margin.
// Latency: out_valid rises NUM_CLASSES clocks after the accepting edge.
// Backpressure: result held while out_ready is low; in_ready only in IDLE, one vector per NUM_CLASSES+2 clocks.
module vmp_argmax_reader
    import vmp_argmax_reader_pkg::*;
(
    input  logic                clk,
    input  logic                GlobalReset,
    vmp_argmax_reader_if.slave  bus
);

    state_t  state_q, state_nxt;
    idx_t    cnt_q;
    score_t  buf_q [NUM_CLASSES];
    score_t  best_q, second_q;
    idx_t    idx_q;
    idx_t    digit_q;
    score_t  max_q;
    margin_t margin_q;

    logic    in_ready_c;
    logic    capture;
    logic    scan_en;
    logic    last_lane;

    score_t  nxt_best, nxt_second;
    idx_t    nxt_idx;
    margin_t margin_nxt;

    assign last_lane = (cnt_q == idx_t'(NUM_CLASSES-1));

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) state_q <= ST_IDLE;
        else              state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        in_ready_c = 1'b0;
        capture    = 1'b0;
        scan_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                scan_en = 1'b1;
                if (last_lane) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    vmp_argmax_reader_max2_update u_max2 (
        .lane       (buf_q[cnt_q]),
        .best       (best_q),
        .second     (second_q),
        .idx        (idx_q),
        .cnt        (cnt_q),
        .first      (cnt_q == '0),
        .nxt_best   (nxt_best),
        .nxt_second (nxt_second),
        .nxt_idx    (nxt_idx)
    );

    // sign-extend both operands so the full best-to-second span fits without wrap
    assign margin_nxt = {nxt_best[SCORE_W-1], nxt_best} - {nxt_second[SCORE_W-1], nxt_second};

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            cnt_q    <= '0;
            best_q   <= '0;
            second_q <= '0;
            idx_q    <= '0;
            digit_q  <= '0;
            max_q    <= '0;
            margin_q <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) buf_q[k] <= '0;
        end else begin
            if (capture) begin
                cnt_q <= '0;
                for (int k = 0; k < NUM_CLASSES; k++) buf_q[k] <= get_lane(bus.scores, k);
            end
            if (scan_en) begin
                cnt_q    <= cnt_q + idx_t'(1);
                best_q   <= nxt_best;
                second_q <= nxt_second;
                idx_q    <= nxt_idx;
                if (last_lane) begin
                    digit_q  <= nxt_idx;
                    max_q    <= nxt_best;
                    margin_q <= margin_nxt;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.digit     = digit_q;
    assign bus.max_score = max_q;
    assign bus.margin    = margin_q;

endmodule

// File: tb/tb_vmp_argmax_reader.sv
// Directed vectors into the arg-max reader; expected results queued at issue, checked by a monitor on handshake.
module tb_vmp_argmax_reader;
    import vmp_argmax_reader_pkg::*;

    typedef struct packed {
        logic [3:0]  digit;
        logic [25:0] max_score;
        logic [26:0] margin;
    } exp_t;

    localparam logic [25:0] NEG_ONE = 26'(-(1 << FRAC_W));

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    vmp_argmax_reader_if bus();

    vmp_argmax_reader dut (
        .clk         (clk),
        .GlobalReset (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic score_vec_t fill(input logic [25:0] v);
        score_vec_t r;
        for (int k = 0; k < NUM_CLASSES; k++) r[k*SCORE_W +: SCORE_W] = v;
        return r;
    endfunction

    function automatic score_vec_t put(input score_vec_t vec, input int k, input logic [25:0] v);
        score_vec_t r;
        r = vec;
        r[k*SCORE_W +: SCORE_W] = v;
        return r;
    endfunction

    function automatic exp_t mk(input logic [3:0] d, input logic [25:0] m, input logic [26:0] g);
        exp_t e;
        e.digit = d; e.max_score = m; e.margin = g;
        return e;
    endfunction

    // monitor: one comparison set per completed result handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digit", 32'(bus.digit), 32'(e.digit));
                check("max_score", 32'(bus.max_score), 32'(e.max_score));
                check("margin", 32'(bus.margin), 32'(e.margin));
            end
        end
    end

    task automatic send(input score_vec_t v, input bit do_lat, input string nm);
        int w;
        int cyc;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.in_ready) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
        bus.scores   = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (do_lat) begin
            cyc = 0;
            while (!bus.out_valid && cyc < 50) begin
                @(posedge clk); #1; cyc++;
            end
            check({nm, "_latency"}, 32'(cyc), 32'd10);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({nm, "_digit"}, 32'(bus.digit), 32'd0);
        check({nm, "_max_score"}, 32'(bus.max_score), 32'd0);
        check({nm, "_margin"}, 32'(bus.margin), 32'd0);
    endtask

    score_vec_t v2, v3, v4, v_tie, v_run;

    initial begin
        int w;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.scores    = '0;

        v2    = fill(26'h0C80000);
        v3    = put(fill(NEG_ONE), 7, 26'h00E0000);
        v4    = put(fill(26'h2000000), 9, 26'h1FFFFFF);
        v_tie = put(put(put(fill(26'h0), 2, 26'h0140000), 5, 26'h0140000), 8, 26'h0100000);
        v_run = put(put(fill(26'h0), 3, 26'h0040000), 6, 26'h0080000);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;

        exp_q.push_back(mk(4'd0, 26'h0C80000, 27'h0));
        send(v2, 1'b1, "all_equal");
        exp_q.push_back(mk(4'd7, 26'h00E0000, 27'h0120000));
        send(v3, 1'b1, "lane7");
        exp_q.push_back(mk(4'd9, 26'h1FFFFFF, 27'h3FFFFFF));
        send(v4, 1'b1, "extremes");
        exp_q.push_back(mk(4'd2, 26'h0140000, 27'h0));
        send(v_tie, 1'b0, "tie");
        exp_q.push_back(mk(4'd6, 26'h0080000, 27'h0040000));
        send(v_run, 1'b0, "runner_up");

        // backpressure: result must hold and new vectors must be refused
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(4'd7, 26'h00E0000, 27'h0120000));
        send(v3, 1'b1, "bp");
        bus.scores   = v4;
        bus.in_valid = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_digit", 32'(bus.digit), 32'd7);
            check("bp_margin", 32'(bus.margin), 32'h0120000);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;

        // reset in the middle of a scan; the partial result is discarded
        send(v4, 1'b0, "abort");
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midscan_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(mk(4'd7, 26'h00E0000, 27'h0120000));
        send(v3, 1'b1, "after_reset");

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk); w++;
        end
        @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
